mem_access_unit: RTL and testbench

Data-memory access engine for the single-cycle femtoRV32 datapath. It takes the MemRead/MemWrite/funct3 command issued by the control unit together with the ALU address and rs2 data, and services it against a word-wide, handshaked, single-port memory that has no byte enables. Sub-word stores become a read-modify-write. The unit stalls the core until the access completes, aligns and extends load data, and flags misaligned or illegal accesses.

---
 rtl/mem_defs.sv | 32 +++
 rtl/lane_align.sv | 40 ++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// Shared funct3 codes, FSM state encoding and access-legality rule for the
// femtoRV32 data-memory access unit.
package mem_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Size/signedness legality plus natural alignment for one access.
  function automatic logic access_legal(input logic       is_store,
                                        input logic [2:0] f3,
                                        input logic [1:0] off);
    case (f3)
      F3_B:    return 1'b1;
      F3_H:    return ~off[0];
      F3_W:    return (off == 2'b00);
      F3_BU:   return ~is_store;
      F3_HU:   return ~is_store & ~off[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge
// into a full memory word.
module lane_align
  import mem_defs::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  f3_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    byte_sel = word_i[{off_i, 3'b000} +: 8];
    half_sel = word_i[{off_i[1], 4'b0000} +: 16];
    load_o   = word_i;
    case (f3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    if (f3_i == F3_B) begin
      merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
    end else if (f3_i == F3_H) begin
      merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
    end else begin
      merge_o = wdata_i;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access FSM: accepts a load/store, drives a handshaked word
// memory (read-modify-write for SB/SH) and stalls the core until done.
module mem_access_unit
  import mem_defs::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [MEM_AW-1:0] m_addr_o,
  output logic [31:0]       m_wdata_o,
  input  logic [31:0]       m_rdata_i,
  input  logic              m_ack_i
);

  state_t            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              store_q, store_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [MEM_AW-1:0] m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        legal;
  logic        accept;
  logic [31:0] load_word;
  logic [31:0] merge_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:MEM_AW+2];

  assign legal  = (mem_read_i ^ mem_write_i) &
                  access_legal(mem_write_i, funct3_i, addr_i[1:0]);
  assign accept = (state_q == IDLE) & legal;

  assign misalign_o = ~rst & (state_q == IDLE) & (mem_read_i | mem_write_i) & ~legal;
  assign stall_o    = ~rst & (accept | (state_q == RD) | (state_q == WR));

  lane_align u_lane_align (
    .word_i  (m_rdata_i),
    .wdata_i (wdata_q),
    .off_i   (off_q),
    .f3_i    (f3_q),
    .load_o  (load_word),
    .merge_o (merge_word)
  );

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    off_d     = off_q;
    store_d   = store_q;
    wdata_d   = wdata_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (legal) begin
          f3_d     = funct3_i;
          off_d    = addr_i[1:0];
          store_d  = mem_write_i;
          wdata_d  = wdata_i;
          m_addr_d = addr_i[MEM_AW+1:2];
          m_req_d  = 1'b1;
          if (mem_write_i && funct3_i == F3_W) begin
            state_d   = WR;
            m_we_d    = 1'b1;
            m_wdata_d = wdata_i;
          end else begin
            state_d = RD;
            m_we_d  = 1'b0;
          end
        end
      end
      RD: begin
        if (m_ack_i) begin
          if (store_q) begin
            // Sub-word store: the read word comes back merged as the write word.
            state_d   = WR;
            m_we_d    = 1'b1;
            m_wdata_d = merge_word;
          end else begin
            state_d = DONE;
            m_req_d = 1'b0;
            rdata_d = load_word;
          end
        end
      end
      WR: begin
        if (m_ack_i) begin
          state_d = DONE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      store_q   <= 1'b0;
      wdata_q   <= 32'h0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      store_q   <= store_d;
      wdata_q   <= wdata_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a behavioural
// memory responder and a spec-level model of load/store results.
module tb_mem_access_unit;

  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_read_i = 1'b0;
  logic              mem_write_i = 1'b0;
  logic [2:0]        funct3_i = 3'b000;
  logic [31:0]       addr_i = 32'h0;
  logic [31:0]       wdata_i = 32'h0;
  logic [31:0]       rdata_o;
  logic              stall_o;
  logic              misalign_o;
  logic              m_req_o;
  logic              m_we_o;
  logic [MEM_AW-1:0] m_addr_o;
  logic [31:0]       m_wdata_o;
  logic [31:0]       m_rdata_i = 32'h0;
  logic              m_ack_i = 1'b0;

  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic [31:0] exp_rdata = 32'h0;
  int n_checks = 0;
  int n_pass   = 0;

  mem_access_unit #(.MEM_AW(MEM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read_i (mem_read_i),
    .mem_write_i(mem_write_i),
    .funct3_i   (funct3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .stall_o    (stall_o),
    .misalign_o (misalign_o),
    .m_req_o    (m_req_o),
    .m_we_o     (m_we_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_rdata_i  (m_rdata_i),
    .m_ack_i    (m_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference rules written from the ISA view: size = funct3[1:0], unsigned = funct3[2].
  function automatic logic model_legal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (rd == wr) return 1'b0;
    if (wr && f3[2]) return 1'b0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
    size = 1 << f3[1:0];
    return (a % size) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] a);
    int sh;
    logic [31:0] v;
    sh = 8 * (a % 4);
    v  = w >> sh;
    case (f3)
      3'b000:  return (v & 32'hFF) | (((v & 32'h80) != 0) ? 32'hFFFF_FF00 : 32'h0);
      3'b100:  return v & 32'hFF;
      3'b001:  return (v & 32'hFFFF) | (((v & 32'h8000) != 0) ? 32'hFFFF_0000 : 32'h0);
      3'b101:  return v & 32'hFFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] mask;
    int sh;
    sh = 8 * (a % 4);
    if (f3 == 3'b010) return wd;
    mask = ((f3 == 3'b000) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Issues one command and plays the memory, acking each request after `delay` waits.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int delay);
    logic        legal;
    logic        rmw;
    int          phases, phase, waits, stalls, writes, widx;
    logic [31:0] exp_word;
    bit          done;
    legal    = model_legal(rd, wr, f3, a);
    rmw      = wr && (f3 != 3'b010);
    phases   = rmw ? 2 : 1;
    widx     = int'((a >> 2) % (1 << MEM_AW));
    exp_word = model_store(mem[widx], wd, f3, a);

    @(negedge clk);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
    m_ack_i = 1'b0;
    #1;
    check({tag, " misalign"}, 32'(misalign_o), 32'(!legal && (rd || wr)));
    check({tag, " stall_accept"}, 32'(stall_o), 32'(legal));
    @(posedge clk);
    #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    funct3_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;

    if (!legal) begin
      @(negedge clk);
      check({tag, " no_req"}, 32'(m_req_o), 32'd0);
      check({tag, " no_stall"}, 32'(stall_o), 32'd0);
      check({tag, " rdata_held"}, rdata_o, exp_rdata);
      return;
    end

    phase = 0; waits = 0; stalls = 1; writes = 0; done = 0;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      @(negedge clk);
      if (!stall_o) begin
        done = 1;
        m_ack_i = 1'b0;
      end else begin
        stalls++;
        check({tag, " req"}, 32'(m_req_o), 32'd1);
        check({tag, " addr"}, 32'(m_addr_o), 32'(widx));
        check({tag, " we"}, 32'(m_we_o), 32'(wr && (phase == phases - 1)));
        if (m_we_o) check({tag, " wdata"}, m_wdata_o, exp_word);
        if (waits == delay) begin
          m_ack_i   = 1'b1;
          m_rdata_i = mem[m_addr_o];
          if (m_we_o) begin
            mem[m_addr_o] = m_wdata_o;
            writes++;
          end
          phase++;
          waits = 0;
        end else begin
          m_ack_i   = 1'b0;
          m_rdata_i = $urandom;
          waits++;
        end
      end
    end
    if (!done) begin
      check({tag, " timeout"}, 32'd1, 32'd0);
      m_ack_i = 1'b0;
      return;
    end
    if (rd) exp_rdata = model_load(mem[widx], f3, a);
    check({tag, " stall_cycles"}, 32'(stalls), 32'(1 + phases * (delay + 1)));
    check({tag, " done_req"}, 32'(m_req_o), 32'd0);
    check({tag, " writes"}, 32'(writes), 32'(wr));
    check({tag, " rdata"}, rdata_o, exp_rdata);
  endtask

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = $urandom;

    // Reset with a legal load presented: stall must stay low throughout.
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst stall", 32'(stall_o), 32'd0);
    check("rst misalign", 32'(misalign_o), 32'd0);
    check("rst req", 32'(m_req_o), 32'd0);
    check("rst we", 32'(m_we_o), 32'd0);
    check("rst addr", 32'(m_addr_o), 32'd0);
    check("rst wdata", m_wdata_o, 32'd0);
    check("rst rdata", rdata_o, 32'd0);
    mem_read_i = 1'b0;
    rst = 1'b0;

    mem[10'h041] = 32'hDEAD_BEEF;
    run_access("lw", 1, 0, 3'b010, 32'h104, 32'h0, 0);
    check("lw value", rdata_o, 32'hDEAD_BEEF);

    mem[10'h040] = 32'h80FF_0000;
    run_access("lb", 1, 0, 3'b000, 32'h103, 32'h0, 0);
    check("lb value", rdata_o, 32'hFFFF_FF80);
    run_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 0);
    check("lbu value", rdata_o, 32'h0000_0080);
    run_access("lhu", 1, 0, 3'b101, 32'h102, 32'h0, 0);
    check("lhu value", rdata_o, 32'h0000_80FF);

    mem[10'h040] = 32'hAABB_CCDD;
    run_access("sb", 0, 1, 3'b000, 32'h102, 32'h1234_5678, 0);
    check("sb memword", mem[10'h040], 32'hAA78_CCDD);

    run_access("lh_mis", 1, 0, 3'b001, 32'h101, 32'h0, 0);
    run_access("sw_mis", 0, 1, 3'b010, 32'h102, 32'h5, 0);
    run_access("both", 1, 1, 3'b010, 32'h100, 32'h5, 0);

    run_access("lw_slow", 1, 0, 3'b010, 32'h104, 32'h0, 3);

    // Spurious ack while idle.
    @(negedge clk);
    m_ack_i = 1'b1;
    @(negedge clk);
    check("idle_ack req", 32'(m_req_o), 32'd0);
    check("idle_ack stall", 32'(stall_o), 32'd0);
    check("idle_ack rdata", rdata_o, exp_rdata);
    m_ack_i = 1'b0;

    // Reset during the write phase of an SH read-modify-write.
    @(negedge clk);
    mem_write_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h202; wdata_i = 32'h0000_BEEF;
    @(posedge clk);
    #1 mem_write_i = 1'b0;
    @(negedge clk);
    m_ack_i = 1'b1; m_rdata_i = mem[m_addr_o];
    @(negedge clk);
    check("sh_rst in_wr", 32'(m_we_o), 32'd1);
    m_ack_i = 1'b0; rst = 1'b1;
    #1 check("sh_rst stall_in_rst", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("sh_rst req", 32'(m_req_o), 32'd0);
    check("sh_rst stall", 32'(stall_o), 32'd0);
    m_ack_i = 1'b1;
    @(negedge clk);
    m_ack_i = 1'b0;
    exp_rdata = 32'h0;
    check("sh_rst late_ack req", 32'(m_req_o), 32'd0);
    check("sh_rst late_ack stall", 32'(stall_o), 32'd0);
    check("sh_rst rdata", rdata_o, 32'h0);

    for (int n = 0; n < 150; n++) begin
      int          r;
      logic        rd, wr;
      logic [31:0] a;
      r  = int'($urandom_range(0, 9));
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_access("rand", rd, wr, 3'($urandom_range(0, 7)), a, $urandom,
                 int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
